// File: rtl/i2c_master_byte_seq_pkg.sv
// Shared I2C defines: bit-controller command encodings and byte-sequencer state encoding.
// Imported by the byte sequencer and by anything that talks to the bit controller.
package i2c_master_byte_seq_pkg;

    typedef logic [3:0] bit_cmd_t;
    typedef logic [2:0] seq_state_t;

    localparam bit_cmd_t I2C_CMD_NOP   = 4'b0000;
    localparam bit_cmd_t I2C_CMD_START = 4'b0001;
    localparam bit_cmd_t I2C_CMD_STOP  = 4'b0010;
    localparam bit_cmd_t I2C_CMD_WRITE = 4'b0100;
    localparam bit_cmd_t I2C_CMD_READ  = 4'b1000;

    localparam seq_state_t ST_IDLE  = 3'd0;
    localparam seq_state_t ST_START = 3'd1;
    localparam seq_state_t ST_WRITE = 3'd2;
    localparam seq_state_t ST_READ  = 3'd3;
    localparam seq_state_t ST_ACK   = 3'd4;
    localparam seq_state_t ST_STOP  = 3'd5;

endpackage

// File: rtl/i2c_master_byte_seq.sv
// I2C byte sequencer: turns start/read/write/stop byte commands into bit-controller commands.
// Latency: one cycle from go to first bit command, cmd_ack one cycle after the final bit_ack.
// Backpressure: host holds its flags until cmd_ack; each bit command is held until its bit_ack. Optional irq via I2C_BYTE_SEQ_IRQ_EN.
module i2c_master_byte_seq
    import i2c_master_byte_seq_pkg::*;
(
    input  logic       clk,
    input  logic       nReset,
    input  logic       ena,
    input  logic       start,
    input  logic       stop,
    input  logic       read,
    input  logic       write,
    input  logic       ack_in,
    input  logic [7:0] din,
    output logic       cmd_ack,
    output logic       ack_out,
    output logic [7:0] dout,
    output logic       i2c_al,
    output logic [3:0] bit_cmd,
    output logic       bit_din,
    input  logic       bit_ack,
    input  logic       bit_al,
    input  logic       bit_dout
`ifdef I2C_BYTE_SEQ_IRQ_EN
    ,
    input  logic       irq_clr,
    output logic       irq
`endif
);

    seq_state_t state_q, state_d;
    bit_cmd_t   bit_cmd_q, bit_cmd_d;
    logic       bit_din_q, bit_din_d;
    logic [7:0] sr_q, sr_d;
    logic [2:0] dcnt_q, dcnt_d;
    logic       cmd_ack_q, cmd_ack_d;
    logic       ack_out_q, ack_out_d;
    logic       i2c_al_q, i2c_al_d;
    logic       go;

    // A lone start flag never launches; the following byte command carries it.
    assign go = ena & (read | write | stop) & ~cmd_ack_q;

    always_comb begin
        state_d   = state_q;
        bit_cmd_d = bit_cmd_q;
        sr_d      = sr_q;
        dcnt_d    = dcnt_q;
        ack_out_d = ack_out_q;
        cmd_ack_d = 1'b0;
        i2c_al_d  = 1'b0;

        if (bit_al) begin
            state_d   = ST_IDLE;
            bit_cmd_d = I2C_CMD_NOP;
            i2c_al_d  = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (go) begin
                        sr_d   = din;
                        dcnt_d = 3'd7;
                        if (start) begin
                            state_d   = ST_START;
                            bit_cmd_d = I2C_CMD_START;
                        end else if (read) begin
                            state_d   = ST_READ;
                            bit_cmd_d = I2C_CMD_READ;
                        end else if (write) begin
                            state_d   = ST_WRITE;
                            bit_cmd_d = I2C_CMD_WRITE;
                        end else begin
                            state_d   = ST_STOP;
                            bit_cmd_d = I2C_CMD_STOP;
                        end
                    end
                end
                ST_START: begin
                    if (bit_ack) begin
                        if (read) begin
                            state_d   = ST_READ;
                            bit_cmd_d = I2C_CMD_READ;
                        end else if (write) begin
                            state_d   = ST_WRITE;
                            bit_cmd_d = I2C_CMD_WRITE;
                        end else begin
                            state_d   = ST_STOP;
                            bit_cmd_d = I2C_CMD_STOP;
                        end
                    end
                end
                ST_WRITE, ST_READ: begin
                    if (bit_ack) begin
                        sr_d = {sr_q[6:0], bit_dout};
                        if (dcnt_q == 3'd0) begin
                            state_d   = ST_ACK;
                            bit_cmd_d = read ? I2C_CMD_WRITE : I2C_CMD_READ;
                        end else begin
                            dcnt_d = dcnt_q - 3'd1;
                        end
                    end
                end
                ST_ACK: begin
                    if (bit_ack) begin
                        ack_out_d = bit_dout;
                        if (stop) begin
                            state_d   = ST_STOP;
                            bit_cmd_d = I2C_CMD_STOP;
                        end else begin
                            state_d   = ST_IDLE;
                            bit_cmd_d = I2C_CMD_NOP;
                            cmd_ack_d = 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (bit_ack) begin
                        state_d   = ST_IDLE;
                        bit_cmd_d = I2C_CMD_NOP;
                        cmd_ack_d = 1'b1;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    bit_cmd_d = I2C_CMD_NOP;
                end
            endcase
        end

        // Data bit follows the command being issued, so it is valid together with bit_cmd.
        if (state_d == ST_WRITE)
            bit_din_d = sr_d[7];
        else if (state_d == ST_ACK)
            bit_din_d = read ? ack_in : 1'b1;
        else
            bit_din_d = 1'b1;
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q   <= ST_IDLE;
            bit_cmd_q <= I2C_CMD_NOP;
            bit_din_q <= 1'b1;
            sr_q      <= 8'h00;
            dcnt_q    <= 3'd0;
            cmd_ack_q <= 1'b0;
            ack_out_q <= 1'b0;
            i2c_al_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cmd_q <= bit_cmd_d;
            bit_din_q <= bit_din_d;
            sr_q      <= sr_d;
            dcnt_q    <= dcnt_d;
            cmd_ack_q <= cmd_ack_d;
            ack_out_q <= ack_out_d;
            i2c_al_q  <= i2c_al_d;
        end
    end

    assign cmd_ack = cmd_ack_q;
    assign ack_out = ack_out_q;
    assign dout    = sr_q;
    assign i2c_al  = i2c_al_q;
    assign bit_cmd = bit_cmd_q;
    assign bit_din = bit_din_q;

`ifdef I2C_BYTE_SEQ_IRQ_EN
    logic irq_q;

    // Set has priority so an event coinciding with a clear is never lost.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset)
            irq_q <= 1'b0;
        else if (cmd_ack_q | i2c_al_q)
            irq_q <= 1'b1;
        else if (irq_clr)
            irq_q <= 1'b0;
    end

    assign irq = irq_q;
`endif

endmodule

// File: doc/i2c_master_byte_seq.md
I2C_MASTER_BYTE_SEQ -- requirements
Module: i2c_master_byte_seq

Interface
REQ-001 SHALL have these ports (clock and reset first):
- clk  input  1  system clock, all state changes on rising edge.
- nReset  input  1  reset, asynchronous, active-low.
- ena  input  1  core enable; 0 blocks acceptance of new byte commands.
- start, stop, read, write  input  1 each  byte-command request flags, held by host until cmd_ack.
- ack_in  input  1  ACK value master drives after a read byte (0=ACK, 1=NACK).
- din  input  8  byte to transmit.
- cmd_ack  output  1  byte command complete, one-cycle pulse.
- ack_out  output  1  ACK bit sampled after a write byte.
- dout  output  8  received byte.
- i2c_al  output  1  arbitration lost, one-cycle pulse.
- bit_cmd  output  4  command to bit controller.
- bit_din  output  1  data bit to bit controller.
- bit_ack  input  1  bit command complete pulse from bit controller.
- bit_al  input  1  arbitration lost from bit controller.
- bit_dout  input  1  sampled SDA from bit controller.
REQ-002 SHALL use bit_cmd encodings NOP=4'b0000, START=4'b0001, STOP=4'b0010, WRITE=4'b0100, READ=4'b1000.

Function
REQ-003 SHALL have states IDLE, START, WRITE, READ, ACK, STOP; one-hot or binary encoding is free.
REQ-004 go = ena & (read|write|stop) & ~cmd_ack; a start flag alone SHALL NOT launch a transaction.
REQ-005 In IDLE with go, the block SHALL load sr<=din and dcnt<=7, then take the first matching branch:
- start -> START, bit_cmd=START.
- read -> READ, bit_cmd=READ.
- write -> WRITE, bit_cmd=WRITE.
- otherwise -> STOP, bit_cmd=STOP.
REQ-006 On bit_ack in START: read -> READ/READ; write -> WRITE/WRITE; neither -> STOP/STOP.
REQ-007 On bit_ack in WRITE or READ:
- sr <= {sr[6:0], bit_dout}.
- If dcnt==0 -> ACK, with bit_cmd=WRITE when reading and bit_cmd=READ when writing.
- Otherwise dcnt <= dcnt-1 and bit_cmd is unchanged.
REQ-008 On bit_ack in ACK:
- ack_out <= bit_dout.
- stop -> STOP/STOP.
- Otherwise -> IDLE, bit_cmd=NOP, cmd_ack=1.
REQ-009 On bit_ack in STOP: -> IDLE, bit_cmd=NOP, cmd_ack=1.
REQ-010 bit_din (registered) SHALL be:
- sr[7] in WRITE.
- ack_in in ACK after a read.
- 1 in ACK after a write.
- 1 otherwise.
REQ-011 bit_cmd SHALL stay stable from issue until the cycle after its bit_ack.
REQ-012 cmd_ack SHALL be high for exactly one cycle per completed byte command.
REQ-013 dout SHALL equal sr continuously; a write byte of 8 bits plus ACK SHALL take exactly 9 bit_ack pulses.
REQ-014 bit_al=1 in any state SHALL force, next edge:
- state=IDLE, bit_cmd=NOP, cmd_ack=0.
- i2c_al=1 for one cycle.
- bit_al overrides a simultaneous bit_ack.
REQ-015 ena falling mid-transaction SHALL NOT abort it; only acceptance in IDLE is gated.
REQ-016 bit_ack received in IDLE SHALL be ignored.

Reset
REQ-017 nReset low SHALL asynchronously set state=IDLE, bit_cmd=NOP, bit_din=1, sr=0, dcnt=0, cmd_ack=0, ack_out=0, i2c_al=0 (and irq=0 when compiled in).

Configuration
REQ-018 With I2C_BYTE_SEQ_IRQ_EN defined, the block SHALL add:
- Input irq_clr and output irq.
- irq sets on cmd_ack|i2c_al and clears on irq_clr; set wins on a same-cycle clash.
REQ-019 Without I2C_BYTE_SEQ_IRQ_EN, irq_clr and irq SHALL NOT exist and behaviour is otherwise identical.

Structure
REQ-020 The bit_cmd encodings and the state encoding SHALL live in the shared I2C defines package; no sub-module; the shift/count logic SHALL stay inline.

Verification
REQ-021 start+write+stop, din=8'hA5, bit model acks every cmd with bit_dout=0:
- bit_cmd sequence START, 8xWRITE with bit_din 1,0,1,0,0,1,0,1, READ, STOP.
- Then one cmd_ack; ack_out=0.
REQ-022 read+ack_in=1, bit_dout stream 1,1,0,0,1,0,1,1:
- dout=8'hCB.
- ACK phase bit_cmd=WRITE with bit_din=1.
- cmd_ack after 9 bit_acks.
REQ-023 stop only -> single STOP command; cmd_ack one cycle after its bit_ack.
REQ-024 bit_al asserted during 4th WRITE bit -> next cycle state IDLE, bit_cmd=NOP, i2c_al pulse, no cmd_ack.
REQ-025 nReset low mid-READ -> all outputs at reset values immediately; with ena=0 and write=1, no command is issued.
REQ-026 With I2C_BYTE_SEQ_IRQ_EN, irq_clr held during the cmd_ack cycle -> irq=1; irq_clr next cycle -> irq=0.
